mix_vg_pipe: RTL and testbench

- Parametrised, flow-controlled successor to the vBlake G-mix pipeline.
- Performs one full G mix on a four-word state (a, b, c, d) using two message words.
- Adds a valid/ready handshake with whole-pipe stall, a tag passthrough, configurable word width and rotations, and a selectable d-finalisation.
- Sits between the round scheduler (message-word permutation) and the state register file in the vBlake round engine.

---
 rtl/mix_vg_pipe.sv | 82 ++++++++
 tb/tb_mix_vg_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_vg_pipe.sv
// mix_vg_pipe: five-stage, valid/ready flow-controlled G mix with tag passthrough and optional d finalisation.
module mix_vg_pipe #(
  parameter int W = 64,
  parameter int R0 = 60,
  parameter int R1 = 43,
  parameter int R2 = 5,
  parameter int R3 = 18,
  parameter int TAG_W = 8,
  parameter bit FINAL_XOR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [W-1:0]     c_i,
  input  logic [W-1:0]     d_i,
  input  logic [W-1:0]     m0,
  input  logic [W-1:0]     m1,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     a_o,
  output logic [W-1:0]     b_o,
  output logic [W-1:0]     c_o,
  output logic [W-1:0]     d_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy
);
  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction
  logic [4:0]       v_q;
  logic [W-1:0]     a_q [5];
  logic [W-1:0]     b_q [5];
  logic [W-1:0]     c_q [5];
  logic [W-1:0]     d_q [5];
  logic [W-1:0]     m_q [2];
  logic [TAG_W-1:0] t_q [5];
  logic             adv;
  logic [W-1:0]     a0, d0, c0, b0, a1, d1, c1, b1, p, d2;
  assign adv = ~v_q[4] | out_ready;
  assign a0 = a_i + b_i + m0;
  assign d0 = rotr(d_i ^ a0, R0);
  assign c0 = c_q[0] + d_q[0];
  assign b0 = rotr(b_q[0] ^ c0, R1);
  assign a1 = a_q[1] + b_q[1] + m_q[1];
  assign d1 = rotr(d_q[1] ^ a1, R2);
  assign c1 = c_q[2] + d_q[2];
  assign b1 = rotr(b_q[2] ^ c1, R3);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      c_q <= '{default: '0};
      d_q <= '{default: '0};
      m_q <= '{default: '0};
      t_q <= '{default: '0};
    end else if (adv) begin
      v_q <= {v_q[3:0], in_valid};
      a_q <= '{a0, a_q[0], a1, a_q[2], a_q[3]};
      b_q <= '{b_i, b0, b_q[1], b1, b_q[3]};
      c_q <= '{c_i, c0, c_q[1], c1, c_q[3]};
      d_q <= '{d0, d_q[0], d1, d_q[2], d_q[3]};
      m_q <= '{m1, m_q[0]};
      t_q <= '{tag_i, t_q[0], t_q[1], t_q[2], t_q[3]};
    end
  end
  // finalisation is formed from the S5 registers, so a cleared pipe shows d_o = ~0 when enabled
  assign p = a_q[4] ^ b_q[4] ^ c_q[4];
  assign d2 = d_q[4] ^ ~p;
  assign d_o = FINAL_XOR ? d2 ^ p : d_q[4];
  assign a_o = a_q[4];
  assign b_o = b_q[4];
  assign c_o = c_q[4];
  assign tag_o = t_q[4];
  assign out_valid = v_q[4];
  assign in_ready = adv;
  assign busy = |v_q;
endmodule

// File: tb/tb_mix_vg_pipe.sv
// tb_mix_vg_pipe: scoreboard bench for mix_vg_pipe in its default 64-bit form and a 32-bit FINAL_XOR=0 form.
module tb_mix_vg_pipe;
  typedef struct {
    logic [63:0] a, b, c, d;
    logic [7:0]  t;
  } res_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] a_i, b_i, c_i, d_i, m0, m1, a_o, b_o, c_o, d_o;
  logic [7:0]  tag_i, tag_o;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [31:0] s_a_i, s_b_i, s_c_i, s_d_i, s_m0, s_m1, s_a_o, s_b_o, s_c_o, s_d_o;
  logic [7:0]  s_tag_i, s_tag_o;
  res_t        q[$];
  res_t        e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          retired = 0;
  int          cyc = 0;
  mix_vg_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_i(a_i), .b_i(b_i), .c_i(c_i), .d_i(d_i), .m0(m0), .m1(m1), .tag_i(tag_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_o(d_o), .tag_o(tag_o), .busy(busy)
  );
  mix_vg_pipe #(.W(32), .R0(16), .R1(12), .R2(8), .R3(7), .TAG_W(8), .FINAL_XOR(1'b0)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a_i(s_a_i), .b_i(s_b_i), .c_i(s_c_i), .d_i(s_d_i), .m0(s_m0), .m1(s_m1), .tag_i(s_tag_i),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .a_o(s_a_o), .b_o(s_b_o), .c_o(s_c_o), .d_o(s_d_o), .tag_o(s_tag_o), .busy(s_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] mask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    return ((x >> n) | (x << (w - n))) & mask(w);
  endfunction
  function automatic res_t mix(input int w, input int r0, input int r1, input int r2, input int r3,
                               input bit fx, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] c, input logic [63:0] d, input logic [63:0] x0,
                               input logic [63:0] x1, input logic [7:0] t);
    res_t r;
    logic [63:0] ma, a0, d0, c0, b0, a1, d1, c1, b1;
    ma = mask(w);
    a0 = (a + b + x0) & ma;
    d0 = rotr(d ^ a0, r0, w);
    c0 = (c + d0) & ma;
    b0 = rotr(b ^ c0, r1, w);
    a1 = (a0 + b0 + x1) & ma;
    d1 = rotr(d0 ^ a1, r2, w);
    c1 = (c0 + d1) & ma;
    b1 = rotr(b0 ^ c1, r3, w);
    r.a = a1;
    r.b = b1;
    r.c = c1;
    r.d = fx ? (~d1 & ma) : d1;
    r.t = t;
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready)
      q.push_back(mix(64, 60, 43, 5, 18, 1'b1, a_i, b_i, c_i, d_i, m0, m1, tag_i));
    if (rst_n && out_valid && out_ready) begin
      n_chk++;
      retired++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: result a=%h tag=%h arrived with no beat outstanding", a_o, tag_o);
      end else begin
        e = q.pop_front();
        if ({a_o, b_o, c_o, d_o, tag_o} !== {e.a, e.b, e.c, e.d, e.t}) begin
          n_fail++;
          $display("FAIL sb_result: got a=%h b=%h c=%h d=%h t=%h expected a=%h b=%h c=%h d=%h t=%h",
                   a_o, b_o, c_o, d_o, tag_o, e.a, e.b, e.c, e.d, e.t);
        end
      end
    end
  end
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic [63:0] d, input logic [63:0] x0, input logic [63:0] x1,
                      input logic [7:0] t, input bit rnd);
    logic ok;
    {a_i, b_i, c_i, d_i, m0, m1, tag_i} = {a, b, c, d, x0, x1, t};
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (ok) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, required 1");
  endtask
  task automatic send_rand(input bit rnd);
    send({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
         {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), rnd);
  endtask
  task automatic drain();
    for (int k = 0; k < 300 && (q.size() != 0 || busy); k++) begin
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: %0d beats outstanding busy=%b, required 0 and 0", q.size(), busy);
    end
  endtask
  task automatic test_reset();
    {in_valid, out_ready, a_i, b_i, c_i, d_i, m0, m1, tag_i} = '0;
    {s_in_valid, s_out_ready, s_a_i, s_b_i, s_c_i, s_d_i, s_m0, s_m1, s_tag_i} = '0;
    #12;
    n_chk++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_ctrl: out_valid,busy,in_ready=%b required 001", {out_valid, busy, in_ready});
    end
    n_chk++;
    if ({a_o, b_o, c_o, tag_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: a=%h b=%h c=%h t=%h required all zero", a_o, b_o, c_o, tag_o);
    end
    n_chk++;
    if (d_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL reset_d_final: got %h required ffffffffffffffff", d_o);
    end
    n_chk++;
    if ({s_d_o, s_out_valid} !== 33'h0) begin
      n_fail++;
      $display("FAIL reset_d_w32: d_o=%h out_valid=%b required 0 and 0", s_d_o, s_out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask
  task automatic test_known_vector();
    res_t r;
    out_ready = 1'b1;
    send(64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 8'h3C, 1'b0);
    in_valid = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (out_valid !== (i == 5)) begin
        n_fail++;
        $display("FAIL kv_latency: out_valid=%b after edge %0d, required %b", out_valid, i, i == 5);
      end
    end
    r = mix(64, 60, 43, 5, 18, 1'b0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 8'h3C);
    n_chk++;
    if (d_o !== ~r.d) begin
      n_fail++;
      $display("FAIL kv_d_is_not_d1: got %h required %h", d_o, ~r.d);
    end
    n_chk++;
    if ({a_o, b_o, c_o, tag_o} !== {r.a, r.b, r.c, 8'h3C}) begin
      n_fail++;
      $display("FAIL kv_words: got a=%h b=%h c=%h t=%h required a=%h b=%h c=%h t=3c",
               a_o, b_o, c_o, tag_o, r.a, r.b, r.c);
    end
    drain();
  endtask
  task automatic test_stream();
    int c0, r0;
    out_ready = 1'b1;
    c0 = cyc;
    r0 = retired;
    for (int i = 0; i < 100; i++) send_rand(1'b0);
    in_valid = 1'b0;
    n_chk++;
    if (cyc - c0 != 100) begin
      n_fail++;
      $display("FAIL stream_rate: 100 beats took %0d cycles, required 100", cyc - c0);
    end
    drain();
    n_chk++;
    if (retired - r0 != 100) begin
      n_fail++;
      $display("FAIL stream_count: retired %0d required 100", retired - r0);
    end
  endtask
  task automatic test_back_to_back_stall();
    logic [63:0] hold_a, hold_d, x;
    logic [7:0]  hold_t;
    int r0;
    r0 = retired;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_rand(1'b0);
    x = {$urandom, $urandom};
    {a_i, b_i, c_i, d_i, m0, m1, tag_i} = {x, ~x, x ^ 64'h55, x + 64'd9, x - 64'd3, ~x + 64'd7, 8'hA5};
    in_valid = 1'b1;
    hold_a = a_o;
    hold_d = d_o;
    hold_t = tag_o;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_chk++;
      if ({in_ready, out_valid} !== 2'b01 || {a_o, d_o, tag_o} !== {hold_a, hold_d, hold_t}) begin
        n_fail++;
        $display("FAIL stall_hold: in_ready=%b out_valid=%b a=%h t=%h required 0 1 a=%h t=%h",
                 in_ready, out_valid, a_o, tag_o, hold_a, hold_t);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(x, ~x, x ^ 64'h55, x + 64'd9, x - 64'd3, ~x + 64'd7, 8'hA5, 1'b0);
    in_valid = 1'b0;
    drain();
    n_chk++;
    if (retired - r0 != 6) begin
      n_fail++;
      $display("FAIL stall_count: retired %0d required 6", retired - r0);
    end
  endtask
  task automatic test_bubbles();
    int r0;
    r0 = retired;
    for (int i = 0; i < 30; i++) begin
      send_rand(1'b1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n_chk++;
      if (busy !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL bubble_busy: busy=%b with %0d beats in flight", busy, q.size());
      end
      @(posedge clk);
      #1;
    end
    drain();
    n_chk++;
    if (retired - r0 != 30) begin
      n_fail++;
      $display("FAIL bubble_count: retired %0d required 30", retired - r0);
    end
  endtask
  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL midreset_ctrl: out_valid,busy,in_ready=%b required 001", {out_valid, busy, in_ready});
    end
    q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL midreset_stale: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
    end
    @(posedge clk);
    #1;
    send(64'h0123_4567_89AB_CDEF, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd11, 64'd13, 8'h5A, 1'b0);
    in_valid = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (out_valid !== (i == 5)) begin
        n_fail++;
        $display("FAIL midreset_latency: out_valid=%b after edge %0d, required %b", out_valid, i, i == 5);
      end
    end
    drain();
  endtask
  task automatic test_param_sweep();
    res_t ex[3];
    s_out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      {s_a_i, s_b_i, s_c_i, s_d_i, s_m0, s_m1} = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (j == 0) {s_a_i, s_b_i, s_c_i, s_d_i, s_m0, s_m1} = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
      s_tag_i = 8'(j + 8'h40);
      s_in_valid = 1'b1;
      ex[j] = mix(32, 16, 12, 8, 7, 1'b0, 64'(s_a_i), 64'(s_b_i), 64'(s_c_i), 64'(s_d_i),
                  64'(s_m0), 64'(s_m1), s_tag_i);
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      n_chk++;
      if ({s_out_valid, s_a_o, s_b_o, s_c_o, s_d_o, s_tag_o} !==
          {1'b1, ex[j].a[31:0], ex[j].b[31:0], ex[j].c[31:0], ex[j].d[31:0], ex[j].t}) begin
        n_fail++;
        $display("FAIL w32_beat%0d: got v=%b a=%h b=%h c=%h d=%h t=%h required v=1 a=%h b=%h c=%h d=%h t=%h",
                 j, s_out_valid, s_a_o, s_b_o, s_c_o, s_d_o, s_tag_o,
                 ex[j].a[31:0], ex[j].b[31:0], ex[j].c[31:0], ex[j].d[31:0], ex[j].t);
      end
      @(posedge clk);
      #1;
    end
    n_chk++;
    if ({s_out_valid, s_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL w32_drain: out_valid,busy=%b required 00", {s_out_valid, s_busy});
    end
  endtask
  initial begin
    test_reset();
    test_known_vector();
    test_stream();
    test_back_to_back_stall();
    test_bubbles();
    test_reset_midflight();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end
endmodule
